// File: rtl/uart_fifo_port.sv
// UART port with independent TX/RX FIFOs, RTS/CTS flow control and sticky error flags.
// Status word on dataOut: {3'b0, frameErr, overrun, txIdle, txFull, rxEmpty, rxHead}.
module uart_fifo_port #(
  parameter int unsigned CLKS_PER_BIT  = 217,
  parameter int unsigned TX_DEPTH_LOG2 = 4,
  parameter int unsigned RX_DEPTH_LOG2 = 4,
  parameter int unsigned RX_HIGH_WATER = 12
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [7:0]  dataIn,
  input  logic        write,
  input  logic        read,
  input  logic        clrErr,
  output logic [15:0] dataOut,
  input  logic        RX,
  output logic        TX,
  input  logic        CTSN,
  output logic        RTSN
);

  localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned TXD = 1 << TX_DEPTH_LOG2;
  localparam int unsigned RXD = 1 << RX_DEPTH_LOG2;
  localparam int unsigned TCW = TX_DEPTH_LOG2 + 1;
  localparam int unsigned RCW = RX_DEPTH_LOG2 + 1;

  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TCW-1:0] TX_FULLC  = TCW'(TXD);
  localparam logic [RCW-1:0] RX_FULLC  = RCW'(RXD);
  localparam logic [RCW-1:0] RX_HW     = RCW'(RX_HIGH_WATER);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  // Input synchronisers
  logic [1:0] rx_sync, cts_sync;
  logic       rx_s, cts_s;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rx_sync  <= '1;
      cts_sync <= '1;
    end else begin
      rx_sync  <= {rx_sync[0], RX};
      cts_sync <= {cts_sync[0], CTSN};
    end
  end

  assign rx_s  = rx_sync[1];
  assign cts_s = cts_sync[1];

  // TX FIFO
  logic [7:0]               tx_mem [TXD];
  logic [TX_DEPTH_LOG2-1:0] tx_wp, tx_rp;
  logic [TCW-1:0]           tx_cnt;
  logic                     tx_full, tx_empty, tx_push, tx_pop;

  assign tx_full  = (tx_cnt == TX_FULLC);
  assign tx_empty = (tx_cnt == '0);
  assign tx_push  = write && !tx_full;

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wp] <= dataIn;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TX_DEPTH_LOG2'(1);
      if (tx_pop)  tx_rp <= tx_rp + TX_DEPTH_LOG2'(1);
      tx_cnt <= tx_cnt + TCW'(tx_push) - TCW'(tx_pop);
    end
  end

  // TX serialiser
  tx_state_t      tx_state, tx_state_n;
  logic [CW-1:0]  tx_tick, tx_tick_n;
  logic [2:0]     tx_bit, tx_bit_n;
  logic [7:0]     tx_sh, tx_sh_n;
  logic           tx_q, tx_d;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      tx_state <= TX_IDLE;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_tick  <= tx_tick_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_tick_n  = tx_tick;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty && !cts_s) begin
          tx_pop     = 1'b1;
          tx_sh_n    = tx_mem[tx_rp];
          tx_tick_n  = '0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick == BIT_LAST) begin
          tx_tick_n  = '0;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end else begin
          tx_tick_n = tx_tick + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_tick == BIT_LAST) begin
          tx_tick_n = '0;
          tx_sh_n   = {1'b0, tx_sh[7:1]};
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
          else                tx_bit_n   = tx_bit + 3'd1;
        end else begin
          tx_tick_n = tx_tick + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_tick == BIT_LAST) begin
          tx_tick_n  = '0;
          tx_state_n = TX_IDLE;
        end else begin
          tx_tick_n = tx_tick + CW'(1);
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // Line level is decoded from the next state so TX is a clean flop output
  always_comb begin
    case (tx_state_n)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_sh_n[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign TX = tx_q;

  // RX deserialiser
  rx_state_t      rx_state, rx_state_n;
  logic [CW-1:0]  rx_tick, rx_tick_n;
  logic [2:0]     rx_bit, rx_bit_n;
  logic [7:0]     rx_sh, rx_sh_n;
  logic           rx_push, rx_push_n, frame_evt;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rx_state <= RX_IDLE;
      rx_tick  <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_push  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_tick  <= rx_tick_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_push  <= rx_push_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_tick_n  = rx_tick;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_push_n  = 1'b0;
    frame_evt  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_tick_n  = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_tick == HALF_LAST) begin
          rx_tick_n  = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_tick_n = rx_tick + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_tick == BIT_LAST) begin
          rx_tick_n = '0;
          rx_sh_n   = {rx_s, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_tick_n = rx_tick + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_tick == BIT_LAST) begin
          rx_tick_n = '0;
          if (rx_s) begin
            rx_push_n  = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            frame_evt  = 1'b1;
            rx_state_n = RX_BREAK;
          end
        end else begin
          rx_tick_n = rx_tick + CW'(1);
        end
      end
      RX_BREAK: begin
        if (rx_s) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // RX FIFO; a pop in the same cycle frees the slot for a push into a full FIFO
  logic [7:0]               rx_mem [RXD];
  logic [RX_DEPTH_LOG2-1:0] rx_wp, rx_rp;
  logic [RCW-1:0]           rx_cnt;
  logic                     rx_full, rx_empty, rx_pop, rx_wr, ovr_evt;
  logic [7:0]               rx_head, rx_last;

  assign rx_full  = (rx_cnt == RX_FULLC);
  assign rx_empty = (rx_cnt == '0);
  assign rx_pop   = read && !rx_empty;
  assign rx_wr    = rx_push && (!rx_full || rx_pop);
  assign ovr_evt  = rx_push && rx_full && !rx_pop;
  assign rx_head  = rx_empty ? rx_last : rx_mem[rx_rp];

  always_ff @(posedge CLK) begin
    if (rx_wr) rx_mem[rx_wp] <= rx_sh;
  end

  logic overrun, frame_err, rtsn_q;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rx_wp     <= '0;
      rx_rp     <= '0;
      rx_cnt    <= '0;
      rx_last   <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rtsn_q    <= 1'b1;
    end else begin
      if (rx_wr)  rx_wp <= rx_wp + RX_DEPTH_LOG2'(1);
      if (rx_pop) rx_rp <= rx_rp + RX_DEPTH_LOG2'(1);
      rx_cnt    <= rx_cnt + RCW'(rx_wr) - RCW'(rx_pop);
      rx_last   <= rx_head;
      overrun   <= (overrun && !clrErr) || ovr_evt;
      frame_err <= (frame_err && !clrErr) || frame_evt;
      rtsn_q    <= (rx_cnt >= RX_HW);
    end
  end

  assign RTSN    = rtsn_q;
  assign dataOut = {3'b000, frame_err, overrun, (tx_empty && tx_state == TX_IDLE),
                    tx_full, rx_empty, rx_head};

endmodule

// File: tb/tb_uart_fifo_port.sv
// Directed/randomised bench for uart_fifo_port; expected bytes and flags come from queue models.
module tb_uart_fifo_port;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned HW    = 12;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [7:0]  dataIn = '0;
  logic        write = 1'b0, read = 1'b0, clrErr = 1'b0;
  logic [15:0] dataOut;
  logic        RX, TX, RTSN;
  logic        CTSN = 1'b0;
  logic        rx_drv = 1'b1, loop = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  rq[$];
  logic [7:0]  tq[$];

  assign RX = loop ? TX : rx_drv;

  uart_fifo_port #(
    .CLKS_PER_BIT (CPB),
    .TX_DEPTH_LOG2(4),
    .RX_DEPTH_LOG2(4),
    .RX_HIGH_WATER(HW)
  ) dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .dataIn (dataIn),
    .write  (write),
    .read   (read),
    .clrErr (clrErr),
    .dataOut(dataOut),
    .RX     (RX),
    .TX     (TX),
    .CTSN   (CTSN),
    .RTSN   (RTSN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_write(input logic [7:0] b);
    @(posedge CLK); #1;
    dataIn = b;
    write  = 1'b1;
    @(posedge CLK); #1;
    write  = 1'b0;
  endtask

  task automatic pulse_read();
    @(posedge CLK); #1;
    read = 1'b1;
    @(posedge CLK); #1;
    read = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge CLK); #1;
    clrErr = 1'b1;
    @(posedge CLK); #1;
    clrErr = 1'b0;
  endtask

  // Drive one frame on RX; a zero stop bit may be held low for extra cycles (break)
  task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned brk);
    rx_drv = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drv = (b >> i) & 8'd1;
      step(CPB);
    end
    rx_drv = stop;
    step(CPB + brk);
    rx_drv = 1'b1;
    step(4);
  endtask

  task automatic wait_tx_start(input int unsigned budget, input string tag);
    int unsigned n;
    n = 0;
    @(negedge CLK);
    while (TX !== 1'b0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(tag, TX, 1'b0);
  endtask

  // Entered at the negedge of the first start-bit cycle; leaves at the negedge after the stop bit
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic e;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      e = 1'b0;
      else if (k == 9) e = 1'b1;
      else             e = ((b >> (k - 1)) & 8'd1) != 0;
      check({tag, "_first"}, TX, e);
      repeat (CPB - 1) @(negedge CLK);
      check({tag, "_last"}, TX, e);
      @(negedge CLK);
    end
  endtask

  task automatic count_low(input int unsigned n, output int unsigned lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (TX !== 1'b1) lows++;
    end
  endtask

  initial begin
    logic [7:0]  b;
    logic        ovr;
    int unsigned lows, n;

    // Reset state
    step(3);
    @(negedge CLK);
    check("rst_dataout", dataOut, 16'h0500);
    check("rst_tx", TX, 1'b1);
    check("rst_rtsn", RTSN, 1'b1);
    @(posedge CLK); #1;
    RSTN = 1'b1;
    step(5);
    @(negedge CLK);
    check("rtsn_low_after_rst", RTSN, 1'b0);

    // Single byte: start bit at n+2, LSB first, txIdle returns
    @(posedge CLK); #1;
    dataIn = 8'hA5;
    write  = 1'b1;
    @(posedge CLK); #1;
    write  = 1'b0;
    @(negedge CLK);
    check("a5_n1_high", TX, 1'b1);
    @(negedge CLK);
    check("a5_n2_low", TX, 1'b0);
    check("a5_busy", dataOut[10], 1'b0);
    check_frame(8'hA5, "a5");
    check("a5_idle", dataOut[10], 1'b1);

    // Loopback, fixed then random bytes
    @(posedge CLK); #1;
    loop = 1'b1;
    pulse_write(8'h3C); rq.push_back(8'h3C);
    pulse_write(8'hC3); rq.push_back(8'hC3);
    step(2 * (10 * CPB + 2) + 30);
    for (int r = 0; r < 5; r++) begin
      if (r > 0) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
          b = 8'($urandom);
          pulse_write(b);
          rq.push_back(b);
        end
        step(n * (10 * CPB + 2) + 30);
      end
      while (rq.size() > 0) begin
        @(negedge CLK);
        check("lb_head", dataOut[8:0], {1'b0, rq[0]});
        pulse_read();
        void'(rq.pop_front());
      end
      @(negedge CLK);
      check("lb_empty", dataOut[8], 1'b1);
    end
    @(posedge CLK); #1;
    loop = 1'b0;

    // 17 frames without reads: overrun, RTSN at high water
    ovr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 0);
      if (rq.size() < DEPTH) rq.push_back(b);
      else ovr = 1'b1;
      @(negedge CLK);
      check("ovf_rtsn", RTSN, rq.size() >= HW);
      check("ovf_flag", dataOut[11], ovr);
      check("ovf_head", dataOut[8:0], {1'b0, rq[0]});
    end
    pulse_clr();
    @(negedge CLK);
    check("ovf_cleared", dataOut[12:11], 2'b00);
    while (rq.size() > 0) begin
      @(negedge CLK);
      check("ovf_drain", dataOut[8:0], {1'b0, rq[0]});
      pulse_read();
      void'(rq.pop_front());
    end
    step(2);
    @(negedge CLK);
    check("ovf_rtsn_release", RTSN, 1'b0);
    check("ovf_empty", dataOut[8], 1'b1);

    // Framing error followed by a held break, then a good frame
    send_frame(8'h55, 1'b0, 3 * CPB);
    @(negedge CLK);
    check("ferr_flags", dataOut[12:11], 2'b10);
    check("ferr_empty", dataOut[8], 1'b1);
    b = 8'($urandom);
    send_frame(b, 1'b1, 0);
    @(negedge CLK);
    check("ferr_rearm", dataOut[8:0], {1'b0, b});
    pulse_clr();
    @(negedge CLK);
    check("ferr_cleared", dataOut[12], 1'b0);
    pulse_read();

    // Short low glitch on RX: nothing logged
    @(posedge CLK); #1;
    rx_drv = 1'b0;
    step(CPB / 2 - 3);
    rx_drv = 1'b1;
    step(3 * CPB);
    @(negedge CLK);
    check("glitch_status", dataOut[12:8], 5'b00101);

    // CTSN high holds TX; release sends queued bytes back to back
    @(posedge CLK); #1;
    CTSN = 1'b1;
    step(4);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      pulse_write(b);
      tq.push_back(b);
    end
    count_low(4 * CPB, lows);
    check("cts_hold", 16'(lows), 16'd0);
    check("cts_status", dataOut[10:9], 2'b00);
    @(posedge CLK); #1;
    CTSN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        wait_tx_start(10, "cts_start");
      end else begin
        check("cts_gap_high", TX, 1'b1);
        @(negedge CLK);
        check("cts_b2b_start", TX, 1'b0);
      end
      if (k == 2) CTSN = 1'b1;
      check_frame(tq[k], "cts_frame");
    end
    check("cts_done_idle", dataOut[10], 1'b1);
    tq.delete();

    // 17 writes with CTSN high: full, 17th lost
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      pulse_write(b);
      if (i < DEPTH) tq.push_back(b);
    end
    @(negedge CLK);
    check("txfull", dataOut[10:9], 2'b01);
    @(posedge CLK); #1;
    CTSN = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 0) begin
        wait_tx_start(10, "full_start");
      end else begin
        check("full_gap_high", TX, 1'b1);
        @(negedge CLK);
        check("full_b2b_start", TX, 1'b0);
      end
      check_frame(tq[k], "full_frame");
    end
    check("full_drained_idle", dataOut[10:9], 2'b10);
    count_low(3 * CPB, lows);
    check("full_17th_lost", 16'(lows), 16'd0);

    // Reset mid-frame, with a second byte still queued
    pulse_write(8'h81);
    pulse_write(8'h7E);
    wait_tx_start(10, "rst_frame_start");
    step(3 * CPB);
    RSTN = 1'b0;
    step(1);
    RSTN = 1'b1;
    @(negedge CLK);
    check("midrst_tx", TX, 1'b1);
    check("midrst_dataout", dataOut, 16'h0500);
    check("midrst_rtsn", RTSN, 1'b1);
    count_low(3 * CPB, lows);
    check("midrst_fifo_cleared", 16'(lows), 16'd0);
    check("midrst_idle", dataOut[10], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
